// File: rtl/serial_frame_source_if.sv
// Word-load handshake and serial output bundle for serial_frame_source.
// master = upstream word producer / bit consumer, slave = the serializer.
interface serial_frame_source_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             flush;
   logic             x_out;
   logic             bit_valid;
   logic             frame_done;

   modport master (
      output data_in, load_valid, flush,
      input  load_ready, x_out, bit_valid, frame_done
   );

   modport slave (
      input  data_in, load_valid, flush,
      output load_ready, x_out, bit_valid, frame_done
   );
endinterface

// File: rtl/serial_frame_source.sv
// Parallel-to-serial frame source: one bit per clock from a shift register,
// with a one-word holding buffer so consecutive frames stream with no gap.
module serial_frame_source #(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input logic                  clock,
   input logic                  reset,
   serial_frame_source_if.slave bus
);
   localparam int             CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
   localparam int             OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_buf;
   logic             r_buf_full;
   logic [CW-1:0]    r_cnt;

   logic             w_load_ready;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_shifted;

   assign w_load_ready = ~r_buf_full & ~bus.flush & reset;
   assign w_accept     = bus.load_valid & w_load_ready;
   assign w_last       = (r_state == ST_SHIFT) && (r_cnt == LAST);
   assign w_shifted    = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_shreg    <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_cnt      <= '0;
      end else if (bus.flush) begin
         r_state    <= ST_IDLE;
         r_buf_full <= 1'b0;
         r_cnt      <= '0;
      end else if (r_state == ST_IDLE || w_last) begin
         // Frame boundary: the buffered word has priority; load_ready is low
         // whenever the buffer is full, so the two loads never collide.
         if (w_last && r_buf_full) begin
            r_shreg    <= r_buf;
            r_buf_full <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_SHIFT;
         end else if (w_accept) begin
            r_shreg <= bus.data_in;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
         end else if (w_last) begin
            r_shreg <= w_shifted;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
         end
      end else begin
         r_shreg <= w_shifted;
         r_cnt   <= r_cnt + 1'b1;
         if (w_accept) begin
            r_buf      <= bus.data_in;
            r_buf_full <= 1'b1;
         end
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.bit_valid  = (r_state == ST_SHIFT);
   assign bus.x_out      = (r_state == ST_SHIFT) ? r_shreg[OUT_IDX] : IDLE_LEVEL;
   assign bus.frame_done = w_last;
endmodule

// File: tb/tb_serial_frame_source.sv
// Scoreboard bench: accepted words expand into expected bit streams for an
// MSB-first and an LSB-first instance sharing one stimulus.
module tb_serial_frame_source;
   localparam int W = 8;

   logic clk;
   logic reset;

   serial_frame_source_if #(.WIDTH(W)) ifa ();
   serial_frame_source_if #(.WIDTH(W)) ifb ();

   serial_frame_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
      .clock (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   serial_frame_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
      .clock (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   logic [W-1:0] data_in;
   logic         load_valid;
   logic         flush;

   assign ifa.data_in    = data_in;
   assign ifa.load_valid = load_valid;
   assign ifa.flush      = flush;
   assign ifb.data_in    = data_in;
   assign ifb.load_valid = load_valid;
   assign ifb.flush      = flush;

   // Each entry is {last_bit_of_frame, bit}
   logic [1:0] qa[$];
   logic [1:0] qb[$];
   int         sz_cur;
   bit         acc_seen;
   bit         chk_en;
   int         checks;
   int         failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a word is accepted iff reset high, flush low and no
   // word waits behind the current frame (more than W bits still pending).
   always @(posedge clk) begin
      if (!reset || flush) begin
         qa.delete();
         qb.delete();
      end else if (load_valid && sz_cur <= W) begin
         acc_seen = 1'b1;
         for (int i = W - 1; i >= 0; i--) qa.push_back({(i == 0), data_in[i]});
         for (int i = 0; i < W; i++)      qb.push_back({(i == W - 1), data_in[i]});
      end
   end

   always @(negedge clk) begin
      logic [1:0] ea;
      logic [1:0] eb;
      logic       ha;
      logic       hb;
      logic       lr;
      sz_cur = qa.size();
      if (chk_en) begin
         ha = (qa.size() > 0);
         hb = (qb.size() > 0);
         ea = ha ? qa[0] : 2'b00;
         eb = hb ? qb[0] : 2'b00;
         lr = reset && !flush && (qa.size() <= W);
         cmp("msb.bit_valid",  ifa.bit_valid,  ha);
         cmp("msb.x_out",      ifa.x_out,      ha ? ea[0] : 1'b0);
         cmp("msb.frame_done", ifa.frame_done, ha & ea[1]);
         cmp("msb.load_ready", ifa.load_ready, lr);
         cmp("lsb.bit_valid",  ifb.bit_valid,  hb);
         cmp("lsb.x_out",      ifb.x_out,      hb ? eb[0] : 1'b1);
         cmp("lsb.frame_done", ifb.frame_done, hb & eb[1]);
         cmp("lsb.load_ready", ifb.load_ready, lr);
      end
      if (ha) void'(qa.pop_front());
      if (hb) void'(qb.pop_front());
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] w);
      bit ok;
      ok         = 1'b0;
      load_valid = 1'b1;
      data_in    = w;
      for (int k = 0; k < 60; k++) begin
         acc_seen = 1'b0;
         @(posedge clk);
         #1;
         if (acc_seen) begin
            ok = 1'b1;
            break;
         end
      end
      load_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_timeout word=%h not accepted within 60 cycles", w);
      end
   endtask

   initial begin
      bit got;
      checks     = 0;
      failures   = 0;
      chk_en     = 1'b0;
      sz_cur     = 0;
      acc_seen   = 1'b0;
      reset      = 1'b0;
      flush      = 1'b0;
      load_valid = 1'b1;
      data_in    = 8'h77;

      // Reset held low three cycles with load_valid high
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      idle(2);
      reset      = 1'b1;
      load_valid = 1'b0;
      idle(2);

      send(8'hB2);
      idle(12);

      // Back-to-back: second word is buffered
      send(8'hFF);
      send(8'h00);
      idle(20);

      // Word offered exactly during the last bit of the current frame
      send(8'h3C);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ifa.frame_done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL frame_done_timeout actual=0 required=1");
      end
      send(8'h0F);
      idle(12);

      // Flush after 3 bits with a buffered word and a simultaneous offer
      send(8'h5A);
      send(8'hA5);
      @(posedge clk);
      #1;
      flush      = 1'b1;
      load_valid = 1'b1;
      data_in    = 8'hC3;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      load_valid = 1'b0;
      idle(12);

      // Reset mid-frame
      send(8'h01);
      idle(3);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      idle(12);

      for (int c = 0; c < 3000; c++) begin
         load_valid = ($urandom_range(0, 99) < 60);
         data_in    = W'($urandom);
         flush      = ($urandom_range(0, 59) == 0);
         reset      = ($urandom_range(0, 249) != 0);
         @(posedge clk);
         #1;
      end
      load_valid = 1'b0;
      flush      = 1'b0;
      reset      = 1'b1;
      idle(2 * W + 4);

      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL drain pending_msb=%0d pending_lsb=%0d required=0", qa.size(), qb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_frame_source.md
# serial_frame_source

Parallel-to-serial frame source that sits directly upstream of the zero-detector FSMs in the Chapter 5 sequential-circuit set. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on `x_out`, which connects to the detector's serial input. A one-word holding buffer lets consecutive words stream back-to-back with no idle cycle between frames.

## Interface
- `WIDTH`, 8: bits per word/frame; must be ≥ 2.
- `MSB_FIRST`, 1: 1 shifts `data_in[WIDTH-1]` first; 0 shifts `data_in[0]` first.
- `IDLE_LEVEL`, 0: value driven on `x_out` when no frame is active.

- `clock`  in  1  rising-edge clock, the block's only clock.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `data_in`  in  WIDTH  word to serialize; sampled on an accepted handshake.
- `load_valid`  in  1  upstream offers `data_in` this cycle.
- `load_ready`  out  1  block can accept a word this cycle.
- `flush`  in  1  synchronous abort: drops the active frame and the buffered word.
- `x_out`  out  1  serial bit stream to the downstream detector.
- `bit_valid`  out  1  high while `x_out` carries a frame bit.
- `frame_done`  out  1  high during the last bit of each frame.

## Operation
- State: `IDLE` or `SHIFT`; WIDTH-bit shift register `shreg`; bit counter `cnt` of width clog2(WIDTH); holding register `buf` with flag `buf_full`.
- Accept: an edge with `load_valid && load_ready` transfers `data_in`. `load_ready = ~buf_full & ~flush & reset`.
- Destination of an accepted word:
  - If, at that edge, the block is in `IDLE` or on the last bit of the current frame (`cnt == WIDTH-1`), and `buf_full = 0`, the word loads directly into `shreg`, `cnt` ← 0, and the state becomes or stays `SHIFT`.
  - Otherwise the word goes to `buf` and `buf_full` ← 1.
- In `SHIFT`, each edge shifts `shreg` toward the output end and increments `cnt`.
- At the last-bit edge:
  - If `buf_full`: `shreg` ← `buf`, `buf_full` ← 0, `cnt` ← 0, and the state stays `SHIFT` with no gap.
  - Else, if no word is accepted at that edge: the state goes to `IDLE`.
- `x_out` = output-end bit of `shreg` (MSB if `MSB_FIRST`, else LSB) in `SHIFT`; `IDLE_LEVEL` in `IDLE`. It is driven from registers only, with no combinational path from inputs.
- `bit_valid` = (state == `SHIFT`).
- `frame_done` = `bit_valid && cnt == WIDTH-1`.
- `buf_full` = 1 implies the state is `SHIFT`; `IDLE` with a full buffer is unreachable.
- `flush` high at an edge:
  - state ← `IDLE`, `buf_full` ← 0, `cnt` ← 0.
  - No word is accepted at that edge, because `load_ready` is forced low while `flush` is high.
- Reset low at an edge:
  - state ← `IDLE`, `shreg` ← 0, `buf` ← 0, `buf_full` ← 0, `cnt` ← 0.
  - Reset overrides `flush` and the handshake; a frame in progress is discarded.

## Timing
- Output values after reset: `x_out = IDLE_LEVEL`, `bit_valid = 0`, `frame_done = 0`. `load_ready = 0` while `reset` is low and 1 in the first cycle after release.
- Latency: a word accepted at edge E while `IDLE` presents bit 0 in the cycle following E and bit WIDTH-1 in cycle E+WIDTH. `frame_done` is high in that cycle only.
- Throughput: 1 bit/clock sustained. A frame of WIDTH bits completes every WIDTH cycles when upstream keeps the buffer filled.
- `load_ready` falls the cycle after a word enters `buf`. It rises the cycle after the last-bit edge that drains `buf`.
- `flush` or reset at edge F: `bit_valid = 0` and `x_out = IDLE_LEVEL` from the cycle after F.

## Test plan
- Reset: hold `reset = 0` for 3 cycles with `load_valid = 1` → `x_out = 0`, `bit_valid = 0`, `load_ready = 0`, no word accepted; after release, `load_ready = 1`.
- Single word (WIDTH=8, MSB_FIRST=1): `8'hB2` accepted at edge E → `x_out` = 1,0,1,1,0,0,1,0 in cycles E+1..E+8; `frame_done` high only in E+8; then `bit_valid = 0` and `x_out = 0`.
- Back-to-back: offer `8'hFF` then `8'h00` with `load_valid` held high → second word is buffered at E+1; `load_ready` is low from E+2 through E+8 and high at E+9; 16 consecutive `bit_valid` cycles (eight 1s, then eight 0s). The downstream zero detector pulses `y_out` once, in cycle E+9.
- Simultaneous event: with the buffer empty, offer `8'h0F` exactly at the last-bit edge of the current frame → it loads directly into `shreg`, with no gap in `bit_valid` and `buf_full` staying 0.
- Flush: assert `flush` after 3 bits of a frame with `8'hA5` buffered, and `load_valid` high on the same edge → the next cycle shows `bit_valid = 0`, the buffered word is dropped, the offered word is not accepted, and `load_ready = 1` once `flush` falls.
- LSB-first with reset mid-frame: MSB_FIRST=0, `8'h01` → first bit 1, then 0s; drop `reset` after bit 4 → the next cycle shows `x_out = IDLE_LEVEL` and `bit_valid = 0`, with no `frame_done`.
